// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through output,
// almost-full/almost-empty thresholds, occupancy count and overflow/underflow pulses.
module fifo_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2,
   parameter bit FWFT     = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       wr,
   input  logic [WIDTH-1:0]           dataIn,
   input  logic                       rd,
   output logic [WIDTH-1:0]           dataOut,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count_r;
   logic             rd_ok;
   logic             wr_ok;

   // Handshake: a request is accepted on a rising edge with en=1; a read needs a
   // non-empty FIFO, a write needs room or a same-edge accepted read. A request
   // that is not accepted raises overflow/underflow for exactly one cycle.
   always_comb begin
      rd_ok = en & rd & ~empty;
      wr_ok = en & wr & (~full | rd_ok);
   end

   always_comb begin
      full         = (count_r == CW'(DEPTH));
      empty        = (count_r == '0);
      almost_full  = (count_r >= CW'(AF_LEVEL));
      almost_empty = (count_r <= CW'(AE_LEVEL));
      count        = count_r;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count_r   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= en & wr & ~wr_ok;
         underflow <= en & rd & ~rd_ok;
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (wr_ok && !rd_ok)
            count_r <= count_r + CW'(1);
         else if (rd_ok && !wr_ok)
            count_r <= count_r - CW'(1);
      end
   end

   // Storage is deliberately not reset; reads never see stale slots because of count.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= dataIn;
   end

   generate
      if (FWFT == 1'b0) begin : g_std
         logic [WIDTH-1:0] dout_r;
         // Holds the last popped word; a write to the read slot on the same edge
         // returns the old contents (no bypass).
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        dout_r <= '0;
            else if (rd_ok) dout_r <= mem[rd_ptr];
         end
         assign dataOut = dout_r;
      end else begin : g_fwft
         assign dataOut = mem[rd_ptr];
      end
   endgenerate

endmodule
